serial_divisibility_by_n: RTL and testbench
===========================================

Name: serial_divisibility_by_n

Overview:
- Serial divisibility checker for an arbitrary divisor.
- Consumes one bit per accepted cycle of an arbitrarily long binary number and keeps the running remainder modulo a runtime-programmable divisor.
- Supports MSB-first and LSB-first bit order, selected per frame.
- Flags when the number received so far is divisible.
- Generalised successor of the fixed-divisor serial checkers in the FSM exercise set; used wherever a bit stream needs an on-the-fly modulo test.

Parameters:
- W, 8: divisor and remainder width in bits; legal divisors are 1 .. 2^W-1.
- CNT_W, 16: width of the received-bit counter.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous active-low reset; asserted when 0.
- start  input  1  begins a new frame; latches divisor and lsb_first.
- divisor  input  W  divisor, sampled only when start=1.
- lsb_first  input  1  bit order, sampled only when start=1: 0 = MSB-first, 1 = LSB-first.
- new_bit_valid  input  1  new_bit is accepted this cycle.
- new_bit  input  1  next bit of the number.
- remainder  output  W  running value mod latched divisor.
- div_by_n  output  1  1 when running value mod divisor == 0 in RUN state.
- error  output  1  1 when frame was started with divisor 0.
- bit_count  output  CNT_W  bits accepted in current frame; saturates at 2^CNT_W-1.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE.
  - remainder=0, div_by_n=0, error=0, bit_count=0.
  - Internal latched divisor d=0, power register p=0, order=0.
- States:
  - IDLE: no frame. div_by_n=0. Bits ignored.
  - RUN: frame active.
  - ERR: illegal divisor. error=1, div_by_n=0, bits ignored.
- Transitions, evaluated at posedge with start=1, from any state:
  - divisor==0 -> ERR. bit_count=0, remainder=0.
  - Otherwise -> RUN:
    - d=divisor, order=lsb_first, remainder=0, bit_count=0.
    - p = (d==1) ? 0 : 1.
- No exit from RUN or ERR other than start or reset.
- Empty frame (RUN, zero bits) represents value 0, so div_by_n=1.
- start and new_bit_valid in the same cycle:
  - The frame is cleared and new_bit is the first bit of the new frame.
  - The bit is processed with the newly sampled divisor and order.
  - If the sampled divisor is 0: ERR, bit discarded.
- Bit update in RUN with new_bit_valid=1. All arithmetic is at W+1 bits with one conditional subtract; r<d always holds, so no division is needed.
  - MSB-first: t = 2*r + new_bit; r' = (t >= d) ? t-d : t.
  - LSB-first:
    - t = r + (new_bit ? p : 0); r' = (t >= d) ? t-d : t.
    - u = 2*p; p' = (u >= d) ? u-d : u.
  - bit_count' = bit_count+1, saturating at all-ones.
- new_bit_valid=0: no state, remainder, p or count change.
- Divisor 1: remainder stays 0; div_by_n=1 throughout RUN.
- Divisor 2^W-1 must work without overflow; this sets the W+1 intermediate width.
- Latency and output timing:
  - Outputs are registered and reflect all bits accepted up to and including the previous posedge.
  - div_by_n is derived from registered state and remainder only (no combinational path from inputs).
- divisor and lsb_first changes outside a start cycle have no effect.

Test Plan:
- MSB-first divisor 5:
  - start (d=5, lsb_first=0), then bits 1,0,1,0 on consecutive valid cycles.
  - Required: remainder 1,2,0,0 and div_by_n 0,0,1,1.
  - Required: bit_count 4.
- LSB-first divisor 3:
  - start (d=3, lsb_first=1), then bits 1,1,1.
  - Required: remainder 1,0,1 (values 1,3,7) and div_by_n 0,1,0.
  - Start without bits gives div_by_n=1, remainder=0.
- Maximum divisor with valid gaps, W=8:
  - start (d=255, MSB-first), eight 1-bits with new_bit_valid toggling 1,0,1,0,...
  - Required: remainder 1,3,7,15,31,63,127,0, holding during gap cycles.
  - Required: div_by_n=1 only after the 8th bit.
- Illegal divisor and recovery:
  - start (d=0), then bits 1,1.
  - Required: error=1, div_by_n=0, remainder=0, bit_count=0.
  - Then start (d=7) with new_bit_valid=1, new_bit=1 in the same cycle.
  - Required: error=0, remainder=1, bit_count=1.
- Restart and divisor 1:
  - Mid-frame (d=5, r=3), start (d=1, MSB-first), then bits 1,0,1.
  - Required: remainder 0 and div_by_n=1 on every cycle after start.
  - Required: divisor input changes after start are ignored.
- Asynchronous reset mid-frame:
  - During RUN with remainder=2, drive rst=0 between clock edges.
  - Required: remainder, div_by_n, error and bit_count go to 0 immediately (before the next posedge).
  - Required: after release, bits are ignored until start.

Source files
------------

// File: rtl/serial_divisibility_by_n.sv
// Serial modulo-N checker: folds one bit per accepted cycle into a running
// remainder against a divisor latched at frame start (MSB- or LSB-first).
module serial_divisibility_by_n #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     divisor,
  input  logic             lsb_first,
  input  logic             new_bit_valid,
  input  logic             new_bit,
  output logic [W-1:0]     remainder,
  output logic             div_by_n,
  output logic             error,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     d_q, d_d;
  logic [W-1:0]     p_q, p_d;
  logic             order_q, order_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Frame context seen by the bit update: the freshly started frame on a
  // start cycle, otherwise the latched one.
  logic             bit_en;
  logic [W-1:0]     cur_d, cur_p, cur_r;
  logic             cur_order;
  logic [CNT_W-1:0] cur_cnt;

  // W+1 bit intermediates so a divisor of 2^W-1 cannot overflow.
  logic [W:0]       d_ext, t_msb, t_lsb, t_sel, t_sub, u, u_sub;

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    p_d       = p_q;
    order_d   = order_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    bit_en    = 1'b0;
    cur_d     = d_q;
    cur_p     = p_q;
    cur_r     = rem_q;
    cur_order = order_q;
    cur_cnt   = cnt_q;

    if (start) begin
      rem_d = '0;
      cnt_d = '0;
      if (divisor == '0) begin
        state_d = ERR;
      end else begin
        state_d   = RUN;
        d_d       = divisor;
        order_d   = lsb_first;
        p_d       = (divisor == W'(1)) ? '0 : W'(1);
        cur_d     = divisor;
        cur_order = lsb_first;
        cur_p     = p_d;
        cur_r     = '0;
        cur_cnt   = '0;
        bit_en    = new_bit_valid;
      end
    end else if (state_q == RUN) begin
      bit_en = new_bit_valid;
    end

    d_ext = {1'b0, cur_d};
    t_msb = {cur_r, new_bit};
    t_lsb = {1'b0, cur_r} + {1'b0, (cur_p & {W{new_bit}})};
    t_sel = cur_order ? t_lsb : t_msb;
    t_sub = (t_sel >= d_ext) ? (t_sel - d_ext) : t_sel;
    u     = {cur_p, 1'b0};
    u_sub = (u >= d_ext) ? (u - d_ext) : u;

    if (bit_en) begin
      rem_d = t_sub[W-1:0];
      if (cur_order) begin
        p_d = u_sub[W-1:0];
      end
      cnt_d = (&cur_cnt) ? cur_cnt : cur_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      p_q     <= '0;
      order_q <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      p_q     <= p_d;
      order_q <= order_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign remainder = rem_q;
  assign bit_count = cnt_q;
  assign error     = (state_q == ERR);
  assign div_by_n  = (state_q == RUN) && (rem_q == '0);

endmodule

// File: tb/tb_serial_divisibility_by_n.sv
// Directed bench for serial_divisibility_by_n with hand-computed expectations.
module tb_serial_divisibility_by_n;

  localparam int W     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     divisor;
  logic             lsb_first;
  logic             new_bit_valid;
  logic             new_bit;
  logic [W-1:0]     remainder;
  logic             div_by_n;
  logic             error;
  logic [CNT_W-1:0] bit_count;

  int checks = 0;
  int errors = 0;

  serial_divisibility_by_n #(.W(W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .divisor       (divisor),
    .lsb_first     (lsb_first),
    .new_bit_valid (new_bit_valid),
    .new_bit       (new_bit),
    .remainder     (remainder),
    .div_by_n      (div_by_n),
    .error         (error),
    .bit_count     (bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic s, input logic [W-1:0] dv, input logic lf,
                     input logic v, input logic b);
    start = s; divisor = dv; lsb_first = lf; new_bit_valid = v; new_bit = b;
    @(posedge clk);
    #1;
    start = 1'b0; new_bit_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int r, input int dn, input int er);
    chk({tag, ".rem"}, 32'(remainder), 32'(r));
    chk({tag, ".div"}, 32'(div_by_n), 32'(dn));
    chk({tag, ".err"}, 32'(error), 32'(er));
  endtask

  initial begin
    int msb5_r[4]   = '{1, 2, 0, 0};
    int msb5_b[4]   = '{1, 0, 1, 0};
    int lsb3_r[3]   = '{1, 0, 1};
    int max_r[8]    = '{1, 3, 7, 15, 31, 63, 127, 0};
    int d1_b[3]     = '{1, 0, 1};

    start = 0; divisor = '0; lsb_first = 0; new_bit_valid = 0; new_bit = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk_out("reset", 0, 0, 0);
    chk("reset.cnt", 32'(bit_count), 0);
    @(posedge clk); #1 rst = 1'b1;

    // Bits before any start are ignored.
    cyc(0, 8'd5, 0, 1, 1);
    chk_out("idle", 0, 0, 0);
    chk("idle.cnt", 32'(bit_count), 0);

    // MSB-first, divisor 5: value 1,2,5,10.
    cyc(1, 8'd5, 0, 0, 0);
    chk_out("msb5.start", 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'd5, 0, 1, msb5_b[i][0]);
      chk_out($sformatf("msb5.b%0d", i), msb5_r[i], (msb5_r[i] == 0) ? 1 : 0, 0);
    end
    chk("msb5.cnt", 32'(bit_count), 4);

    // LSB-first, divisor 3: values 1,3,7.
    cyc(1, 8'd3, 1, 0, 0);
    chk_out("lsb3.start", 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'd3, 1, 1, 1);
      chk_out($sformatf("lsb3.b%0d", i), lsb3_r[i], (lsb3_r[i] == 0) ? 1 : 0, 0);
    end
    chk("lsb3.cnt", 32'(bit_count), 3);

    // Maximum divisor with gaps between valid bits.
    cyc(1, 8'd255, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 8'd255, 0, 1, 1);
      chk_out($sformatf("max.b%0d", i), max_r[i], (i == 7) ? 1 : 0, 0);
      cyc(0, 8'd255, 0, 0, 1);
      chk($sformatf("max.gap%0d", i), 32'(remainder), 32'(max_r[i]));
    end
    chk("max.cnt", 32'(bit_count), 8);

    // Illegal divisor, bits ignored, then recovery with bit on the start cycle.
    cyc(1, 8'd0, 0, 0, 0);
    cyc(0, 8'd0, 0, 1, 1);
    cyc(0, 8'd0, 0, 1, 1);
    chk_out("err", 0, 0, 1);
    chk("err.cnt", 32'(bit_count), 0);
    cyc(1, 8'd7, 0, 1, 1);
    chk_out("rec", 1, 0, 0);
    chk("rec.cnt", 32'(bit_count), 1);

    // Start with divisor 0 and a valid bit: bit discarded.
    cyc(1, 8'd0, 0, 1, 1);
    chk_out("err2", 0, 0, 1);
    chk("err2.cnt", 32'(bit_count), 0);

    // Mid-frame restart onto divisor 1; later divisor changes ignored.
    cyc(1, 8'd5, 0, 0, 0);
    cyc(0, 8'd5, 0, 1, 1);
    cyc(0, 8'd5, 0, 1, 1);
    chk("mid.rem", 32'(remainder), 3);
    cyc(1, 8'd1, 0, 0, 0);
    chk_out("d1.start", 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'd9, 1, 1, d1_b[i][0]);
      chk_out($sformatf("d1.b%0d", i), 0, 1, 0);
    end
    chk("d1.cnt", 32'(bit_count), 3);

    // Changes of divisor/order outside start: d=5 MSB-first frame stays intact.
    cyc(1, 8'd5, 0, 0, 0);
    cyc(0, 8'd3, 1, 1, 1);
    cyc(0, 8'd3, 1, 1, 1);
    cyc(0, 8'd3, 1, 1, 1);
    chk("ign.rem", 32'(remainder), 2);  // 7 mod 5

    // Asynchronous reset between edges.
    cyc(1, 8'd5, 0, 0, 0);
    cyc(0, 8'd5, 0, 1, 1);
    cyc(0, 8'd5, 0, 1, 0);
    chk("ar.pre", 32'(remainder), 2);
    #2 rst = 1'b0;
    #1;
    chk_out("ar", 0, 0, 0);
    chk("ar.cnt", 32'(bit_count), 0);
    #1 rst = 1'b1;
    cyc(0, 8'd5, 0, 1, 1);
    cyc(0, 8'd5, 0, 1, 1);
    chk_out("ar.idle", 0, 0, 0);
    chk("ar.idle.cnt", 32'(bit_count), 0);
    cyc(1, 8'd5, 0, 1, 1);
    chk_out("ar.restart", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
